core_tile_ctrl: RTL
===================

CORE_TILE_CTRL -- requirements
Module: core_tile_ctrl

Interface
REQ-001 Parameter TILE_DIM, default 8, meaning pixels per tile side.
REQ-002 Parameter BEATS_PER_TILE, default 48, meaning 32-bit AHB beats per tile (64 px x 3 B / 4).
REQ-003 Parameter XFER_CYCLES, default 64, meaning core pixel-copy cycles per tile.
REQ-004 I_HCLK  in  1  the one clock; all state on its rising edge.
REQ-005 I_HRESET  in  1  reset, asynchronous, active-high.
REQ-006 I_START  in  1  one-cycle job start pulse.
REQ-007 I_HEIGHT, I_WIDTH  in  16 each  image size in pixels.
REQ-008 I_DIRECTION  in  1  1 = counter-clockwise, 0 = clockwise.
REQ-009 I_DEGREES  in  2  0/1/2/3 = 0/90/180/270 degrees.
REQ-010 I_DMA_READY  in  1  DMA accepts or supplies one beat this cycle.
REQ-011 O_DMA_RD_REQ, O_DMA_WR_REQ  out  1 each  tile read (AHB to input buffer) / tile write (output buffer to AHB) request.
REQ-012 O_SRC_TILE_X, O_SRC_TILE_Y  out  13 each  source tile column/row.
REQ-013 O_DST_TILE_X, O_DST_TILE_Y  out  13 each  destination tile column/row.
REQ-014 O_BEAT_CNT  out  6  beats completed in current LOAD/STORE.
REQ-015 O_CORE_START  out  1  one-cycle pulse starting the pixel-core copy.
REQ-016 O_BUSY, O_DONE, O_ERR  out  1 each  job active / job-complete pulse / bad-dimension pulse.

Function
REQ-017 FSM states: IDLE, CHECK, LOAD, XFER, STORE, NEXT, DONE.
REQ-018 IDLE: I_START=1 -> CHECK next cycle; I_HEIGHT, I_WIDTH, I_DIRECTION, I_DEGREES captured into job registers on that edge.
REQ-019 I_START outside IDLE is ignored; a job runs only on its captured values.
REQ-020 CHECK: height or width zero or not a multiple of TILE_DIM -> O_ERR=1 one cycle, then IDLE; else NX=W/8, NY=H/8, tile (0,0), -> LOAD.
REQ-021 LOAD: O_DMA_RD_REQ=1; each cycle with I_DMA_READY=1 increments O_BEAT_CNT; beat BEATS_PER_TILE-1 accepted -> XFER with O_BEAT_CNT cleared.
REQ-022 XFER entry: O_CORE_START=1 exactly one cycle; remain XFER_CYCLES cycles (counter independent of I_DMA_READY) -> STORE.
REQ-023 STORE: O_DMA_WR_REQ=1; beat counting as LOAD; last beat accepted -> NEXT.
REQ-024 NEXT (1 cycle): tx+1; if tx=NX-1 then tx=0, ty+1; if (tx,ty)=(NX-1,NY-1) before increment -> DONE, else LOAD.
REQ-025 DONE: O_DONE=1 one cycle -> IDLE.
REQ-026 Effective angle: CCW90 = CW270, CCW270 = CW90, 0 and 180 direction-independent.
REQ-027 Destination mapping from source (tx,ty): 0 -> (tx,ty); CW90 -> (NY-1-ty, tx); 180 -> (NX-1-tx, NY-1-ty); CW270 -> (ty, NX-1-tx); computed combinationally from registered tile indices, stable from LOAD entry through STORE exit.
REQ-028 O_DMA_RD_REQ and O_DMA_WR_REQ never high together; I_DMA_READY ignored outside LOAD/STORE.
REQ-029 O_BUSY=1 in every state except IDLE.
REQ-030 Tile arithmetic 13-bit unsigned; NX-1 and NY-1 never underflow because CHECK rejects zero.

Reset
REQ-031 I_HRESET=1 forces IDLE immediately, at any state including mid-LOAD/STORE; the current job is abandoned.
REQ-032 Reset values: all outputs 0, all counters and job registers 0.
REQ-033 First I_START after reset deassertion is honoured on the next clock edge.

Structure
REQ-034 Shared package holds state encodings, DEG_0/90/180/270 and direction constants, TILE_DIM, BEATS_PER_TILE, XFER_CYCLES.
REQ-035 One sub-module, core_tile_map: combinational source-to-destination tile coordinate mapping (REQ-026/027).

Verification
REQ-036 8x8, 0 deg, READY tied high: RD_REQ 48 cycles, CORE_START pulse, 64 XFER cycles, WR_REQ 48 cycles, O_DONE once; DST=(0,0).
REQ-037 W=16 H=8, CW90: source tiles (0,0),(1,0) -> destinations (0,0),(0,1); CCW270 gives identical sequence.
REQ-038 16x16, 180 deg, READY toggling 1/0: source (0,0)->dest (1,1) ... (1,1)->(0,0); beats counted only on READY=1; 4 tiles then O_DONE.
REQ-039 H=12 W=8 -> O_ERR pulse 2 cycles after I_START, no DMA request, back to IDLE; H=0 -> same.
REQ-040 Reset asserted at LOAD beat 20 -> outputs 0 same cycle; a new I_START then runs a full job from tile (0,0).
REQ-041 I_START pulsed during XFER -> ignored; job registers unchanged, exactly one O_DONE.

Source files
------------

// File: rtl/core_tile_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// core_tile_ctrl_pkg
// Shared constants for the tile-rotation controller:
//   - default tile geometry / DMA / core timing parameters
//   - FSM state encodings
//   - rotation angle and direction codes
//   - eff_cw_angle(): folds a (direction, angle) pair into a clockwise angle
// ----------------------------------------------------------------------------
package core_tile_ctrl_pkg;

   localparam int TILE_DIM       = 8;   // pixels per tile side
   localparam int BEATS_PER_TILE = 48;  // 32-bit beats per tile (64 px x 3 B / 4)
   localparam int XFER_CYCLES    = 64;  // core pixel-copy cycles per tile

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_CHECK = 3'd1;
   localparam logic [2:0] ST_LOAD  = 3'd2;
   localparam logic [2:0] ST_XFER  = 3'd3;
   localparam logic [2:0] ST_STORE = 3'd4;
   localparam logic [2:0] ST_NEXT  = 3'd5;
   localparam logic [2:0] ST_DONE  = 3'd6;

   localparam logic [1:0] DEG_0   = 2'd0;
   localparam logic [1:0] DEG_90  = 2'd1;
   localparam logic [1:0] DEG_180 = 2'd2;
   localparam logic [1:0] DEG_270 = 2'd3;

   localparam logic DIR_CW  = 1'b0;
   localparam logic DIR_CCW = 1'b1;

   // A counter-clockwise turn by d quarter turns equals a clockwise turn by
   // (4 - d) mod 4, so 90 and 270 swap while 0 and 180 are unchanged.
   function automatic logic [1:0] eff_cw_angle(input logic dir, input logic [1:0] deg);
      if (dir == DIR_CCW) begin
         return 2'd0 - deg;
      end
      return deg;
   endfunction

endpackage

// File: rtl/core_tile_ctrl_map.sv
// ----------------------------------------------------------------------------
// core_tile_map
// Combinational source-to-destination tile coordinate mapping.
// Ports:
//   i_tx, i_ty     source tile column / row
//   i_nx, i_ny     tiles per row / per column (never zero while in use)
//   i_dir          1 = counter-clockwise, 0 = clockwise
//   i_deg          0/1/2/3 = 0/90/180/270 degrees
//   o_dst_x/y      destination tile column / row
// ----------------------------------------------------------------------------
module core_tile_map
   import core_tile_ctrl_pkg::*;
(
   input  logic [12:0] i_tx,
   input  logic [12:0] i_ty,
   input  logic [12:0] i_nx,
   input  logic [12:0] i_ny,
   input  logic        i_dir,
   input  logic [1:0]  i_deg,
   output logic [12:0] o_dst_x,
   output logic [12:0] o_dst_y
);

   logic [1:0] w_angle;

   assign w_angle = eff_cw_angle(i_dir, i_deg);

   always_comb begin
      o_dst_x = i_tx;
      o_dst_y = i_ty;
      case (w_angle)
         DEG_90: begin
            o_dst_x = i_ny - 13'd1 - i_ty;
            o_dst_y = i_tx;
         end
         DEG_180: begin
            o_dst_x = i_nx - 13'd1 - i_tx;
            o_dst_y = i_ny - 13'd1 - i_ty;
         end
         DEG_270: begin
            o_dst_x = i_ty;
            o_dst_y = i_nx - 13'd1 - i_tx;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/core_tile_ctrl.sv
// ----------------------------------------------------------------------------
// core_tile_ctrl
// Walks an image tile by tile: DMA-loads a tile, starts the pixel core for a
// fixed copy time, DMA-stores the tile at its rotated position, repeats.
// Ports:
//   I_HCLK, I_HRESET            clock, asynchronous active-high reset
//   I_START                     one-cycle job start (honoured only in IDLE)
//   I_HEIGHT, I_WIDTH           image size in pixels
//   I_DIRECTION, I_DEGREES      rotation direction / quarter turns
//   I_DMA_READY                 DMA moves one beat this cycle
//   O_DMA_RD_REQ, O_DMA_WR_REQ  tile load / tile store request
//   O_SRC_TILE_X/Y              current source tile
//   O_DST_TILE_X/Y              rotated destination tile
//   O_BEAT_CNT                  beats completed in current load/store
//   O_CORE_START                one-cycle pulse starting the pixel core
//   O_BUSY, O_DONE, O_ERR       job active / job done pulse / bad size pulse
// ----------------------------------------------------------------------------
module core_tile_ctrl #(
   parameter int TILE_DIM       = core_tile_ctrl_pkg::TILE_DIM,
   parameter int BEATS_PER_TILE = core_tile_ctrl_pkg::BEATS_PER_TILE,
   parameter int XFER_CYCLES    = core_tile_ctrl_pkg::XFER_CYCLES
) (
   input  logic        I_HCLK,
   input  logic        I_HRESET,
   input  logic        I_START,
   input  logic [15:0] I_HEIGHT,
   input  logic [15:0] I_WIDTH,
   input  logic        I_DIRECTION,
   input  logic [1:0]  I_DEGREES,
   input  logic        I_DMA_READY,
   output logic        O_DMA_RD_REQ,
   output logic        O_DMA_WR_REQ,
   output logic [12:0] O_SRC_TILE_X,
   output logic [12:0] O_SRC_TILE_Y,
   output logic [12:0] O_DST_TILE_X,
   output logic [12:0] O_DST_TILE_Y,
   output logic [5:0]  O_BEAT_CNT,
   output logic        O_CORE_START,
   output logic        O_BUSY,
   output logic        O_DONE,
   output logic        O_ERR
);
   import core_tile_ctrl_pkg::*;

   localparam logic [15:0] DIM16     = 16'(TILE_DIM);
   localparam logic [5:0]  LAST_BEAT = 6'(BEATS_PER_TILE - 1);
   localparam logic [15:0] LAST_XFER = 16'(XFER_CYCLES - 1);

   logic [2:0]  r_state;
   logic [15:0] r_height;
   logic [15:0] r_width;
   logic        r_dir;
   logic [1:0]  r_deg;
   logic [12:0] r_nx;
   logic [12:0] r_ny;
   logic [12:0] r_tx;
   logic [12:0] r_ty;
   logic [5:0]  r_beat_cnt;
   logic [15:0] r_xfer_cnt;
   logic        r_err;

   logic        w_bad_dim;
   logic        w_row_end;
   logic        w_last_tile;

   assign w_bad_dim = (r_width == 16'd0) || (r_height == 16'd0) ||
                      ((r_width % DIM16) != 16'd0) || ((r_height % DIM16) != 16'd0);
   assign w_row_end   = (r_tx == r_nx - 13'd1);
   assign w_last_tile = w_row_end && (r_ty == r_ny - 13'd1);

   always_ff @(posedge I_HCLK or posedge I_HRESET) begin
      if (I_HRESET) begin
         r_state    <= ST_IDLE;
         r_height   <= '0;
         r_width    <= '0;
         r_dir      <= 1'b0;
         r_deg      <= '0;
         r_nx       <= '0;
         r_ny       <= '0;
         r_tx       <= '0;
         r_ty       <= '0;
         r_beat_cnt <= '0;
         r_xfer_cnt <= '0;
         r_err      <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (I_START) begin
                  r_height <= I_HEIGHT;
                  r_width  <= I_WIDTH;
                  r_dir    <= I_DIRECTION;
                  r_deg    <= I_DEGREES;
                  r_state  <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               // The error pulse is registered, so it appears the cycle after CHECK.
               if (w_bad_dim) begin
                  r_err   <= 1'b1;
                  r_state <= ST_IDLE;
               end else begin
                  r_nx    <= 13'(r_width / DIM16);
                  r_ny    <= 13'(r_height / DIM16);
                  r_tx    <= '0;
                  r_ty    <= '0;
                  r_state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (I_DMA_READY) begin
                  if (r_beat_cnt == LAST_BEAT) begin
                     r_beat_cnt <= '0;
                     r_xfer_cnt <= '0;
                     r_state    <= ST_XFER;
                  end else begin
                     r_beat_cnt <= r_beat_cnt + 6'd1;
                  end
               end
            end
            ST_XFER: begin
               if (r_xfer_cnt == LAST_XFER) begin
                  r_xfer_cnt <= '0;
                  r_state    <= ST_STORE;
               end else begin
                  r_xfer_cnt <= r_xfer_cnt + 16'd1;
               end
            end
            ST_STORE: begin
               if (I_DMA_READY) begin
                  if (r_beat_cnt == LAST_BEAT) begin
                     r_beat_cnt <= '0;
                     r_state    <= ST_NEXT;
                  end else begin
                     r_beat_cnt <= r_beat_cnt + 6'd1;
                  end
               end
            end
            ST_NEXT: begin
               if (w_row_end) begin
                  r_tx <= '0;
                  r_ty <= r_ty + 13'd1;
               end else begin
                  r_tx <= r_tx + 13'd1;
               end
               r_state <= w_last_tile ? ST_DONE : ST_LOAD;
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   core_tile_map u_map (
      .i_tx    (r_tx),
      .i_ty    (r_ty),
      .i_nx    (r_nx),
      .i_ny    (r_ny),
      .i_dir   (r_dir),
      .i_deg   (r_deg),
      .o_dst_x (O_DST_TILE_X),
      .o_dst_y (O_DST_TILE_Y)
   );

   assign O_DMA_RD_REQ = (r_state == ST_LOAD);
   assign O_DMA_WR_REQ = (r_state == ST_STORE);
   assign O_SRC_TILE_X = r_tx;
   assign O_SRC_TILE_Y = r_ty;
   assign O_BEAT_CNT   = r_beat_cnt;
   assign O_CORE_START = (r_state == ST_XFER) && (r_xfer_cnt == 16'd0);
   assign O_BUSY       = (r_state != ST_IDLE);
   assign O_DONE       = (r_state == ST_DONE);
   assign O_ERR        = r_err;

endmodule
